// File: rtl/seqgen_pkg.sv
// Shared definitions for the 6-bit sequence generator and its detector benches.
package seqgen_pkg;

   localparam int unsigned SeqW = 6;
   localparam logic [SeqW-1:0] SeqPattern = 6'b110011;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap,
      StDone
   } seq_state_e;

endpackage

// File: rtl/seqgen_down_counter.sv
// Loadable down counter with a zero flag; decrement saturates at zero.
module seqgen_down_counter #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic [Width-1:0] cnt_o,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/generate_6_bit_sequence_using_fsm.sv
// Serialises PATTERN MSB-first for a requested number of repetitions with an idle gap between.
module generate_6_bit_sequence_using_fsm
   import seqgen_pkg::*;
#(
   parameter int unsigned W       = SeqW,
   parameter logic [W-1:0] PATTERN = SeqPattern,
   parameter int unsigned REP_W   = 8,
   parameter int unsigned GAP_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [REP_W-1:0] reps,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             out_bit,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BitCntW = (W > 1) ? $clog2(W) : 1;

   seq_state_e       state_q, state_d;
   logic [W-1:0]     shreg_q, shreg_d;
   logic [GAP_W-1:0] gap_q, gap_d;

   logic               bit_load, bit_dec, bit_zero;
   logic [BitCntW-1:0] bit_cnt;
   logic               rep_load, rep_dec, rep_zero;
   logic [REP_W-1:0]   rep_left;
   logic               gap_load, gap_dec, gap_zero;
   logic [GAP_W-1:0]   gap_cnt;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      gap_d    = gap_q;
      bit_load = 1'b0;
      bit_dec  = 1'b0;
      rep_load = 1'b0;
      rep_dec  = 1'b0;
      gap_load = 1'b0;
      gap_dec  = 1'b0;
      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (reps != '0) begin
                     rep_load = 1'b1;
                     gap_d    = gap;
                     shreg_d  = PATTERN;
                     bit_load = 1'b1;
                     state_d  = StShift;
                  end else begin
                     state_d = StDone;
                  end
               end
            end
            StShift: begin
               if (bit_zero) begin
                  if (rep_left == REP_W'(1)) begin
                     state_d = StDone;
                  end else begin
                     rep_dec = 1'b1;
                     if (gap_q == '0) begin
                        shreg_d  = PATTERN;
                        bit_load = 1'b1;
                     end else begin
                        gap_load = 1'b1;
                        state_d  = StGap;
                     end
                  end
               end else begin
                  shreg_d = shreg_q << 1;
                  bit_dec = 1'b1;
               end
            end
            StGap: begin
               // gap_cnt was loaded with gap-1, so this state lasts exactly gap cycles
               if (gap_zero) begin
                  shreg_d  = PATTERN;
                  bit_load = 1'b1;
                  state_d  = StShift;
               end else begin
                  gap_dec = 1'b1;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         shreg_q <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         gap_q   <= gap_d;
      end
   end

   seqgen_down_counter #(
      .Width (BitCntW)
   ) u_bit_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (bit_load),
      .load_val_i (BitCntW'(W - 1)),
      .dec_i      (bit_dec),
      .cnt_o      (bit_cnt),
      .zero_o     (bit_zero)
   );

   seqgen_down_counter #(
      .Width (REP_W)
   ) u_rep_left (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (rep_load),
      .load_val_i (reps),
      .dec_i      (rep_dec),
      .cnt_o      (rep_left),
      .zero_o     (rep_zero)
   );

   seqgen_down_counter #(
      .Width (GAP_W)
   ) u_gap_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (gap_load),
      .load_val_i (gap_q - GAP_W'(1)),
      .dec_i      (gap_dec),
      .cnt_o      (gap_cnt),
      .zero_o     (gap_zero)
   );

   logic unused_cnt;
   assign unused_cnt = rep_zero ^ (^bit_cnt) ^ (^gap_cnt);

   // Moore outputs: a reset forces state_q to StIdle and clears them without a clock
   assign out_valid = (state_q == StShift);
   assign out_bit   = out_valid & shreg_q[W-1];
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);

endmodule

// File: tb/tb_generate_6_bit_sequence_using_fsm.sv
// Directed bench for the 6-bit sequence generator: per-cycle output traces against hand vectors.
module tb_generate_6_bit_sequence_using_fsm;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] reps;
   logic [3:0] gap;
   logic       abort;
   logic       out_bit;
   logic       out_valid;
   logic       busy;
   logic       done;

   int total;
   int bad;

   // per-cycle observation: {out_valid, out_bit, busy, done}
   logic [3:0] obs [0:63];

   generate_6_bit_sequence_using_fsm dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .reps      (reps),
      .gap       (gap),
      .abort     (abort),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic pulse_start(input logic [7:0] r, input logic [3:0] g);
      @(posedge clk);
      #1;
      reps  = r;
      gap   = g;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs[i] = {out_valid, out_bit, busy, done};
      end
   endtask

   task automatic test_reset;
      total++;
      if ({out_valid, out_bit, busy, done} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_held got=%b want=0000", {out_valid, out_bit, busy, done});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      capture(2);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs[i] !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle cycle %0d got=%b want=0000", i, obs[i]);
         end
      end
   endtask

   task automatic test_single;
      logic [9:0] ev, eb, ey, ed;
      ev = 10'b1111110000;
      eb = 10'b1100110000;
      ey = 10'b1111111000;
      ed = 10'b0000001000;
      pulse_start(8'd1, 4'd0);
      capture(10);
      for (int i = 0; i < 10; i++) begin
         total++;
         if (obs[i] !== {ev[9-i], eb[9-i], ey[9-i], ed[9-i]}) begin
            bad++;
            $display("FAIL single cycle %0d got=%b want=%b", i, obs[i],
                     {ev[9-i], eb[9-i], ey[9-i], ed[9-i]});
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [21:0] ev, eb, ey, ed;
      int          dcount;
      ev = 22'b111111_111111_111111_0000;
      eb = 22'b110011_110011_110011_0000;
      ey = 22'b111111_111111_111111_1000;
      ed = 22'b000000_000000_000000_1000;
      dcount = 0;
      pulse_start(8'd3, 4'd0);
      capture(22);
      for (int i = 0; i < 22; i++) begin
         if (obs[i][0]) dcount++;
         total++;
         if (obs[i] !== {ev[21-i], eb[21-i], ey[21-i], ed[21-i]}) begin
            bad++;
            $display("FAIL b2b cycle %0d got=%b want=%b", i, obs[i],
                     {ev[21-i], eb[21-i], ey[21-i], ed[21-i]});
         end
      end
      total++;
      if (dcount !== 1) begin
         bad++;
         $display("FAIL b2b_done_pulses got=%0d want=1", dcount);
      end
   endtask

   task automatic test_gap;
      logic [17:0] ev, eb, ey, ed;
      logic [5:0]  hist;
      int          hits;
      ev = 18'b111111_000_111111_000;
      eb = 18'b110011_000_110011_000;
      ey = 18'b111111_111_111111_100;
      ed = 18'b000000_000_000000_100;
      hist = 6'b000000;
      hits = 0;
      pulse_start(8'd2, 4'd3);
      capture(18);
      for (int i = 0; i < 18; i++) begin
         total++;
         if (obs[i] !== {ev[17-i], eb[17-i], ey[17-i], ed[17-i]}) begin
            bad++;
            $display("FAIL gap cycle %0d got=%b want=%b", i, obs[i],
                     {ev[17-i], eb[17-i], ey[17-i], ed[17-i]});
         end
         // loopback 110011 detector fed only with valid bits
         if (obs[i][3]) begin
            hist = {hist[4:0], obs[i][2]};
            if (hist == 6'b110011) hits++;
         end
      end
      total++;
      if (hits !== 2) begin
         bad++;
         $display("FAIL gap_loopback_detects got=%0d want=2", hits);
      end
   endtask

   task automatic test_zero_reps;
      logic [3:0] ey, ed;
      ey = 4'b1000;
      ed = 4'b1000;
      pulse_start(8'd0, 4'd5);
      capture(4);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (obs[i] !== {1'b0, 1'b0, ey[3-i], ed[3-i]}) begin
            bad++;
            $display("FAIL zero_reps cycle %0d got=%b want=%b", i, obs[i],
                     {1'b0, 1'b0, ey[3-i], ed[3-i]});
         end
      end
   endtask

   task automatic test_abort;
      logic [9:0] ev, eb;
      logic [7:0] nv, nb, nd;
      ev = 10'b1111110011;
      eb = 10'b1100110011;
      pulse_start(8'd4, 4'd2);
      capture(10);
      for (int i = 0; i < 10; i++) begin
         total++;
         if (obs[i] !== {ev[9-i], eb[9-i], 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL abort_pre cycle %0d got=%b want=%b", i, obs[i],
                     {ev[9-i], eb[9-i], 1'b1, 1'b0});
         end
      end
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      capture(6);
      for (int i = 0; i < 6; i++) begin
         total++;
         if (obs[i] !== 4'b0000) begin
            bad++;
            $display("FAIL abort_post cycle %0d got=%b want=0000", i, obs[i]);
         end
      end
      nv = 8'b11111100;
      nb = 8'b11001100;
      nd = 8'b00000010;
      pulse_start(8'd1, 4'd0);
      capture(8);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs[i] !== {nv[7-i], nb[7-i], nv[7-i] | nd[7-i], nd[7-i]}) begin
            bad++;
            $display("FAIL abort_restart cycle %0d got=%b want=%b", i, obs[i],
                     {nv[7-i], nb[7-i], nv[7-i] | nd[7-i], nd[7-i]});
         end
      end
   endtask

   task automatic test_abort_edges;
      // abort on the final bit: no done pulse
      pulse_start(8'd1, 4'd0);
      capture(5);
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      capture(4);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (obs[i] !== 4'b0000) begin
            bad++;
            $display("FAIL abort_last_bit cycle %0d got=%b want=0000", i, obs[i]);
         end
      end
      // start and abort together in idle: start dropped
      @(posedge clk);
      #1;
      reps  = 8'd2;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      capture(4);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (obs[i] !== 4'b0000) begin
            bad++;
            $display("FAIL start_with_abort cycle %0d got=%b want=0000", i, obs[i]);
         end
      end
   endtask

   task automatic test_async_reset;
      pulse_start(8'd2, 4'd0);
      capture(3);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({out_valid, out_bit, busy, done} !== 4'b0000) begin
         bad++;
         $display("FAIL async_reset got=%b want=0000", {out_valid, out_bit, busy, done});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      capture(3);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs[i] !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset_idle cycle %0d got=%b want=0000", i, obs[i]);
         end
      end
   endtask

   task automatic test_busy_ignore;
      logic [17:0] ev, eb, ey, ed;
      ev = 18'b111111_0_111111_00000;
      eb = 18'b110011_0_110011_00000;
      ey = 18'b111111_1_111111_10000;
      ed = 18'b000000_0_000000_10000;
      pulse_start(8'd2, 4'd1);
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         obs[i] = {out_valid, out_bit, busy, done};
         // new request and changed parameters while busy, held through DONE
         if (i == 1) begin
            start = 1'b1;
            reps  = 8'd5;
            gap   = 4'd7;
         end
         if (i == 14) start = 1'b0;
      end
      for (int i = 0; i < 18; i++) begin
         total++;
         if (obs[i] !== {ev[17-i], eb[17-i], ey[17-i], ed[17-i]}) begin
            bad++;
            $display("FAIL busy_ignore cycle %0d got=%b want=%b", i, obs[i],
                     {ev[17-i], eb[17-i], ey[17-i], ed[17-i]});
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      start = 1'b0;
      reps  = 8'd0;
      gap   = 4'd0;
      abort = 1'b0;
      #12;
      test_reset();
      test_single();
      test_back_to_back();
      test_gap();
      test_zero_reps();
      test_abort();
      test_abort_edges();
      test_async_reset();
      test_busy_ignore();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
